// File: rtl/uart_bus_bridge.sv
// UART command responder bridging a host byte stream onto a single-byte req/ack register bus.
//
// Protocol: 'W' addr_hi addr_lo data -> bus write, reply ACK_BYTE.
//           'R' addr_hi addr_lo      -> bus read,  reply is the read byte.
//           any other opcode         -> reply NAK_BYTE.
// Inter-byte timeouts, framing errors, unknown opcodes and bytes arriving while a command is
// in flight all bump a saturating error counter.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rx_valid, rx_data, rx_error   received byte strobe / data / framing error pulse
//   tx_start, tx_data, tx_busy    reply byte request / data / transmitter activity
//   bus_req, bus_we, bus_addr,    register bus request and its attributes, held until bus_ack
//   bus_wdata, bus_ack, bus_rdata
//   busy                          high whenever a command or reply is in progress
//   err_count                     saturating protocol error count
module uart_bus_bridge #(
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter logic [7:0]  CMD_WRITE      = 8'h57,
   parameter logic [7:0]  CMD_READ       = 8'h52,
   parameter logic [7:0]  ACK_BYTE       = 8'h4B,
   parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   input  logic                  rx_error,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   input  logic                  tx_busy,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [7:0]            bus_wdata,
   input  logic                  bus_ack,
   input  logic [7:0]            bus_rdata,
   output logic                  busy,
   output logic [7:0]            err_count
);

   localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TimerWidth-1:0] TimerLoad = TimerWidth'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      StIdle,
      StAddrHi,
      StAddrLo,
      StData,
      StBus,
      StSend,
      StSendWait
   } state_e;

   state_e                state;
   logic                  op_write;
   logic [7:0]            addr_hi;
   logic [7:0]            addr_lo;
   logic [TimerWidth-1:0] timer;
   logic                  send_first;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         op_write   <= 1'b0;
         addr_hi    <= 8'h00;
         addr_lo    <= 8'h00;
         timer      <= '0;
         send_first <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= 8'h00;
         busy       <= 1'b0;
         err_count  <= 8'h00;
      end else begin
         tx_start <= 1'b0;
         case (state)
            StIdle: begin
               if (rx_error) begin
                  err_count <= sat_inc(err_count);
               end else if (rx_valid) begin
                  if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                     op_write <= (rx_data == CMD_WRITE);
                     timer    <= TimerLoad;
                     state    <= StAddrHi;
                     busy     <= 1'b1;
                  end else begin
                     err_count <= sat_inc(err_count);
                     tx_data   <= NAK_BYTE;
                     state     <= StSend;
                     busy      <= 1'b1;
                  end
               end
            end

            // Byte-collection states share error/timeout handling; the error beats a
            // simultaneous byte, and a byte beats a simultaneous timeout.
            StAddrHi, StAddrLo, StData: begin
               if (rx_error) begin
                  err_count <= sat_inc(err_count);
                  state     <= StIdle;
                  busy      <= 1'b0;
               end else if (rx_valid) begin
                  timer <= TimerLoad;
                  if (state == StAddrHi) begin
                     addr_hi <= rx_data;
                     state   <= StAddrLo;
                  end else if (state == StAddrLo) begin
                     addr_lo <= rx_data;
                     if (op_write) begin
                        state <= StData;
                     end else begin
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= ADDR_WIDTH'({addr_hi, rx_data});
                        state    <= StBus;
                     end
                  end else begin
                     bus_req   <= 1'b1;
                     bus_we    <= 1'b1;
                     bus_addr  <= ADDR_WIDTH'({addr_hi, addr_lo});
                     bus_wdata <= rx_data;
                     state     <= StBus;
                  end
               end else if (timer == '0) begin
                  err_count <= sat_inc(err_count);
                  state     <= StIdle;
                  busy      <= 1'b0;
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            StBus: begin
               if (rx_valid) begin
                  err_count <= sat_inc(err_count);
               end
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  tx_data <= op_write ? ACK_BYTE : bus_rdata;
                  state   <= StSend;
               end
            end

            StSend: begin
               if (rx_valid) begin
                  err_count <= sat_inc(err_count);
               end
               if (!tx_busy) begin
                  tx_start   <= 1'b1;
                  send_first <= 1'b1;
                  state      <= StSendWait;
               end
            end

            StSendWait: begin
               if (rx_valid) begin
                  err_count <= sat_inc(err_count);
               end
               // The UART raises its busy flag one cycle after tx_start, so skip one cycle.
               if (send_first) begin
                  send_first <= 1'b0;
               end else if (!tx_busy) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state   <= StIdle;
               bus_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Responder on the far side of the UART byte interface: consumes received bytes, decodes a 3/4-byte command protocol, issues single-byte reads/writes on a req/ack register bus, and returns one reply byte through the UART transmit interface.
- Sits between the uart instance and the on-chip register/memory bus; gives a host PC debug access to the SoC.

Parameters:
- ADDR_WIDTH, 16, bus address width; the address is always carried as 2 bytes on the wire and truncated to ADDR_WIDTH LSBs.
- TIMEOUT_CYCLES, 2000000, clk cycles allowed between consecutive bytes of one command (80 ms at 25 MHz).
- CMD_WRITE, 8'h57, opcode byte 'W'.
- CMD_READ, 8'h52, opcode byte 'R'.
- ACK_BYTE, 8'h4B, reply byte 'K' for a completed write.
- NAK_BYTE, 8'h3F, reply byte '?' for an unknown opcode.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  one-cycle pulse: rx_data holds a new byte (driven by UART received).
- rx_data  in  8  received byte.
- rx_error  in  1  one-cycle pulse: UART framing error.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data (drives UART transmit).
- tx_data  out  8  byte to send; held stable from the tx_start cycle until the reply completes.
- tx_busy  in  1  UART transmitter active (is_transmitting).
- bus_req  out  1  bus request, held until bus_ack.
- bus_we  out  1  1 = write, 0 = read; valid while bus_req is high.
- bus_addr  out  ADDR_WIDTH  bus address; valid while bus_req is high.
- bus_wdata  out  8  write data; valid while bus_req is high.
- bus_ack  in  1  bus completion, sampled on the rising edge while bus_req is high.
- bus_rdata  in  8  read data; valid in the cycle where bus_ack is high.
- busy  out  1  high whenever state != IDLE.
- err_count  out  8  saturating count of protocol errors.

Behaviour:
- Reset values: tx_start=0, tx_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, busy=0, err_count=0. State returns to IDLE and the timeout counter clears.
- Reset mid-operation aborts with no reply. bus_req is low on the cycle after rst is sampled.
- Outputs are registered. Every state change occurs on the clk edge where its condition is sampled.
- Wire protocol:
  - Write: W, addr_hi, addr_lo, data. Reply ACK_BYTE.
  - Read: R, addr_hi, addr_lo. Reply is the read data byte.
- States:
  - IDLE:
    - rx_valid with CMD_WRITE or CMD_READ: latch the op, load timeout, go to ADDR_HI.
    - rx_valid with any other byte: err_count+1, load tx_data=NAK_BYTE, go to SEND.
  - ADDR_HI: on rx_valid, latch addr[15:8] and go to ADDR_LO.
  - ADDR_LO: on rx_valid, latch addr[7:0]. A read goes to BUS; a write goes to DATA.
  - DATA: on rx_valid, latch wdata and go to BUS.
  - BUS:
    - bus_req=1, with bus_addr, bus_we and bus_wdata stable.
    - On bus_ack: drop bus_req the next cycle. tx_data=bus_rdata for a read, ACK_BYTE for a write. Go to SEND.
    - No bus timeout; the bus must always acknowledge.
  - SEND:
    - When tx_busy=0, pulse tx_start for exactly one cycle and go to SEND_WAIT.
    - While tx_busy=1, wait.
  - SEND_WAIT:
    - Ignore tx_busy in the first cycle (the UART flag is one cycle late).
    - After that, go to IDLE when tx_busy=0.
- Latency:
  - Final command byte rx_valid at edge N gives bus_req=1 after edge N.
  - bus_ack sampled at edge M gives the earliest tx_start=1 after edge M+1.
- Timeout:
  - The counter reloads on each accepted byte and decrements every cycle in ADDR_HI, ADDR_LO and DATA.
  - On reaching 0: err_count+1, go to IDLE, no reply.
- rx_error:
  - In IDLE, ADDR_HI, ADDR_LO or DATA: err_count+1, go to IDLE, no reply.
  - In other states: ignored.
- A byte received in BUS, SEND or SEND_WAIT is discarded and counts err_count+1.
- err_count saturates at 8'hFF; further errors do not wrap.
- Simultaneous events:
  - rx_error and rx_valid in the same cycle: the error wins and the byte is dropped.
  - rx_valid in the same cycle the timeout expires: the byte wins and the timeout reloads.

Test Plan:
- Write: bytes 57,12,34,A5 -> one bus_req with bus_we=1, bus_addr=16'h1234, bus_wdata=8'hA5; ack after 3 cycles -> tx_start once with tx_data=4B, busy low after tx_busy falls.
- Read: bytes 52,00,10, bus_rdata=8'h3C with ack -> bus_we=0, bus_addr=16'h0010; tx_data=3C sent once; err_count stays 0.
- Bad opcode 0x41 -> tx_data=3F sent, err_count=1, no bus_req.
- Timeout: 57,12 then silence for TIMEOUT_CYCLES+1 cycles -> return to IDLE, err_count+1, no bus_req, no tx_start; next full write succeeds.
- Back-pressure: hold tx_busy=1 at the time of the read ack -> tx_start stays low until tx_busy falls, then exactly one pulse. Assert rst during BUS -> bus_req=0 next cycle, no reply.
- Saturation: 300 bad opcodes -> err_count=FF. A mid-command rx_error pulse -> abort with no reply.
